// File: rtl/uart_rx_wb_fetcher.sv
// uart_rx_wb_fetcher: Wishbone master that drains UART RX bytes into a first-word-fall-through byte FIFO
// Ports: wb_clk_i/wb_rst_n clock and async active-low reset; enable_i/uart_irq_i wake-up controls;
// m_* Wishbone master to the UART slave; rx_data_o/rx_valid_o/rx_ready_i downstream byte stream;
// fifo_level_o entries held; bus_err_o sticky bus timeout flag.
module uart_rx_wb_fetcher #(
  parameter logic [31:0] STATUS_ADDR = 32'h0000_0010,
  parameter logic [31:0] RXDATA_ADDR = 32'h0000_0000,
  parameter int RX_EMPTY_BIT = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int POLL_CYCLES = 1024,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic wb_clk_i,
  input  logic wb_rst_n,
  input  logic enable_i,
  input  logic uart_irq_i,
  output logic m_cyc_o,
  output logic m_stb_o,
  output logic m_we_o,
  output logic [3:0] m_sel_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  input  logic m_ack_i,
  output logic [7:0] rx_data_o,
  output logic rx_valid_o,
  input  logic rx_ready_i,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
  output logic bus_err_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = POLL_CYCLES > 1 ? $clog2(POLL_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  typedef enum logic [1:0] {IDLE, RD_STAT, RD_DATA} state_t;
  state_t state, state_n;
  logic cyc, cyc_n, err, err_n, push, pop, full, room, poll_hit, trig;
  logic [PW-1:0] pcnt, pcnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] level;
  logic unused_dat;
  assign unused_dat = ^m_dat_i;
  assign pop = rx_valid_o & rx_ready_i;
  assign full = level == LW'(FIFO_DEPTH);
  // a data read may be followed by another status read only if a slot is still free after its push
  assign room = pop | (level < LW'(FIFO_DEPTH - 1));
  assign poll_hit = (POLL_CYCLES != 0) && (pcnt == PW'(POLL_CYCLES - 1));
  assign trig = enable_i & (uart_irq_i | poll_hit);
  // In RD_STAT/RD_DATA, cyc=0 marks the one-cycle idle gap that precedes the bus cycle.
  always_comb begin
    state_n = state;
    cyc_n = cyc;
    err_n = err;
    pcnt_n = pcnt;
    tcnt_n = tcnt;
    push = 1'b0;
    if (state == IDLE) begin
      if (trig && !full) begin
        state_n = RD_STAT;
        cyc_n = 1'b1;
        pcnt_n = '0;
      end else if (!(trig && full && poll_hit)) begin
        pcnt_n = poll_hit ? '0 : pcnt + PW'(1);
      end
    end else if (!cyc) begin
      cyc_n = enable_i;
      state_n = enable_i ? state : IDLE;
    end else if (m_ack_i) begin
      cyc_n = 1'b0;
      tcnt_n = '0;
      push = state == RD_DATA;
      state_n = state == RD_STAT ? (m_dat_i[RX_EMPTY_BIT] ? IDLE : RD_DATA) :
                (enable_i && room ? RD_STAT : IDLE);
    end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
      cyc_n = 1'b0;
      tcnt_n = '0;
      err_n = 1'b1;
      state_n = IDLE;
    end else begin
      tcnt_n = tcnt + TW'(1);
    end
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state <= IDLE;
      cyc <= 1'b0;
      err <= 1'b0;
      pcnt <= '0;
      tcnt <= '0;
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      state <= state_n;
      cyc <= cyc_n;
      err <= err_n;
      pcnt <= pcnt_n;
      tcnt <= tcnt_n;
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      level <= level + LW'(push) - LW'(pop);
    end
  end
  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wp] <= m_dat_i[7:0];
  end
  assign m_cyc_o = cyc;
  assign m_stb_o = cyc;
  assign m_we_o = 1'b0;
  assign m_sel_o = {4{cyc}};
  assign m_adr_o = cyc ? (state == RD_DATA ? RXDATA_ADDR : STATUS_ADDR) : '0;
  assign m_dat_o = '0;
  assign rx_valid_o = level != '0;
  assign rx_data_o = rx_valid_o ? mem[rp] : '0;
  assign fifo_level_o = level;
  assign bus_err_o = err;
endmodule

// File: tb/tb_uart_rx_wb_fetcher.sv
// tb_uart_rx_wb_fetcher: self-checking bench with a Wishbone UART slave model and an in-order byte scoreboard
module tb_uart_rx_wb_fetcher;
  localparam logic [31:0] STAT = 32'h0000_0010;
  localparam logic [31:0] RXD = 32'h0000_0000;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, irq = 1'b0, ready = 1'b0;
  logic cyc, stb, we, ack, rx_valid, err;
  logic [3:0] sel, level;
  logic [31:0] adr, dat_o, dat_i;
  logic [7:0] rx_data;
  always #5 clk = ~clk;
  uart_rx_wb_fetcher #(.POLL_CYCLES(16), .TIMEOUT_CYCLES(64), .FIFO_DEPTH(8)) dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .enable_i(enable), .uart_irq_i(irq),
    .m_cyc_o(cyc), .m_stb_o(stb), .m_we_o(we), .m_sel_o(sel), .m_adr_o(adr),
    .m_dat_o(dat_o), .m_dat_i(dat_i), .m_ack_i(ack),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(ready),
    .fifo_level_o(level), .bus_err_o(err)
  );
  logic [7:0] smem [256];
  int sh = 0, st = 0, ws = 0, wcnt = 0;
  bit noack = 1'b0;
  assign ack = cyc & stb & ~noack & (wcnt >= ws);
  assign dat_i = adr == RXD ? {24'h5A5A5A, smem[sh % 256]} : {16'hBEEF, 14'h0, sh == st, 1'b1};
  always @(posedge clk) begin
    wcnt <= (cyc && !ack) ? wcnt + 1 : 0;
    if (ack && adr == RXD) sh <= sh + 1;
  end
  typedef struct { int n; int ws; bit use_irq; int pct; int exp_max; } vec_t;
  vec_t vecs[5];
  logic [7:0] exp_q[$];
  logic [31:0] addr_log[$];
  int n_cmp = 0, n_fail = 0, delivered = 0, n_dreads = 0, cyc_hi = 0, max_lvl = 0;
  task automatic check(string name, logic [31:0] act, logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask
  task automatic sample();
    logic [7:0] e;
    if (cyc && ack) begin
      addr_log.push_back(adr);
      if (adr == RXD) n_dreads++;
    end
    if (cyc) begin
      cyc_hi++;
      check("sel_we", {sel, 3'b0, we}, {4'hF, 4'h0});
    end
    if (int'(level) > max_lvl) max_lvl = int'(level);
    if (rx_valid && ready) begin
      delivered++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_byte: got %0h, want none", rx_data);
      end else begin
        e = exp_q.pop_front();
        check("rx_byte", rx_data, e);
      end
    end
  endtask
  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask
  task automatic load(logic [7:0] b);
    smem[st % 256] = b;
    st++;
    exp_q.push_back(b);
  endtask
  task automatic wait_drain(int lim);
    for (int c = 0; c < lim && exp_q.size() != 0; c++) tick();
    check("drained", exp_q.size(), 0);
  endtask
  task automatic settle();
    repeat (4) tick();
    for (int c = 0; c < 200 && cyc; c++) tick();
    check("settle_idle", cyc, 0);
  endtask
  initial begin
    int k;
    vecs[0] = '{1, 0, 1'b1, 100, 1};
    vecs[1] = '{5, 1, 1'b1, 100, 1};
    vecs[2] = '{20, 3, 1'b1, 100, 1};
    vecs[3] = '{10, 2, 1'b0, 50, -1};
    vecs[4] = '{16, 0, 1'b1, 30, -1};
    repeat (3) tick();
    check("rst_cyc_stb_we", {cyc, stb, we}, 0);
    check("rst_adr", adr, 0);
    check("rst_sel", sel, 0);
    check("rst_dat_o", dat_o, 0);
    check("rst_level", level, 0);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_err", err, 0);
    load(8'h3C);
    enable = 1'b1;
    rst_n = 1'b1;
    k = 0;
    while (!cyc && k < 100) begin
      tick();
      k++;
    end
    check("poll_delay", k, 16);
    check("poll_adr", adr, STAT);
    ready = 1'b1;
    delivered = 0;
    wait_drain(200);
    check("poll_delivered", delivered, 1);
    settle();
    ready = 1'b0;
    addr_log.delete();
    delivered = 0;
    load(8'hA5);
    irq = 1'b1;
    tick();
    irq = 1'b0;
    for (int c = 0; c < 100 && addr_log.size() < 3; c++) tick();
    check("sb_nacks", addr_log.size(), 3);
    check("sb_adr0", addr_log[0], STAT);
    check("sb_adr1", addr_log[1], RXD);
    check("sb_adr2", addr_log[2], STAT);
    tick();
    check("sb_idle", cyc, 0);
    check("sb_valid", rx_valid, 1);
    check("sb_data", rx_data, 8'hA5);
    check("sb_err", err, 0);
    ready = 1'b1;
    wait_drain(50);
    check("sb_level", level, 0);
    settle();
    ready = 1'b0;
    n_dreads = 0;
    delivered = 0;
    for (int i = 1; i <= 12; i++) load(8'(i));
    irq = 1'b1;
    repeat (120) tick();
    check("burst_dreads", n_dreads, 8);
    check("burst_level", level, 8);
    cyc_hi = 0;
    repeat (40) tick();
    check("burst_no_bus", cyc_hi, 0);
    ready = 1'b1;
    wait_drain(400);
    irq = 1'b0;
    check("burst_delivered", delivered, 12);
    foreach (vecs[i]) begin
      settle();
      ws = vecs[i].ws;
      delivered = 0;
      max_lvl = 0;
      irq = vecs[i].use_irq;
      for (int j = 0; j < vecs[i].n; j++) load(8'($urandom_range(255)));
      for (int c = 0; c < 4000 && exp_q.size() != 0; c++) begin
        ready = ($urandom_range(99) < vecs[i].pct);
        tick();
      end
      irq = 1'b0;
      ready = 1'b1;
      check("vec_drained", exp_q.size(), 0);
      check("vec_delivered", delivered, vecs[i].n);
      if (vecs[i].exp_max >= 0) check("vec_max_level", max_lvl, vecs[i].exp_max);
      check("vec_err", err, 0);
    end
    settle();
    ws = 0;
    noack = 1'b1;
    irq = 1'b1;
    tick();
    irq = 1'b0;
    k = 0;
    while (!cyc && k < 50) begin
      tick();
      k++;
    end
    check("to_started", cyc, 1);
    cyc_hi = 0;
    k = 0;
    while (cyc && k < 200) begin
      tick();
      k++;
    end
    check("to_len", cyc_hi, 64);
    check("to_err", err, 1);
    check("to_level", level, 0);
    k = 0;
    while (!cyc && k < 40) begin
      tick();
      k++;
    end
    check("to_repoll", cyc, 1);
    noack = 1'b0;
    repeat (30) tick();
    check("to_err_sticky", err, 1);
    settle();
    ws = 5;
    ready = 1'b0;
    load(8'h11);
    load(8'h22);
    irq = 1'b1;
    k = 0;
    while (!(cyc && adr == RXD && level == 4'd1) && k < 200) begin
      tick();
      k++;
    end
    check("mr_in_data", {cyc, stb, level}, {2'b11, 4'd1});
    rst_n = 1'b0;
    #1;
    check("mr_cyc_stb", {cyc, stb}, 0);
    check("mr_level", level, 0);
    check("mr_valid", rx_valid, 0);
    check("mr_adr", adr, 0);
    irq = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
